// File: rtl/mem_wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_wb_pkg                                                 |
// | Description : Shared types, lane-map constants and the lane-merge helper |
// |               for the memory write buffer.                               |
// | Contents    : mem_wb_entry_t  - one queued store {addr, data, en}        |
// |               c_LANE*         - lane enable bit i <-> data byte mapping  |
// |               lane_merge()    - overlay enabled lanes onto an entry      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_wb_pkg;

  localparam int unsigned c_ADDR_W    = 30;  // word address width
  localparam int unsigned c_DATA_W    = 32;
  localparam int unsigned c_LANES     = 4;
  localparam int unsigned c_LANE_W    = 8;
  // Lane 0 is the most significant byte: en[i] covers data[31-8i -: 8].
  localparam int unsigned c_LANE0_MSB = 31;

  typedef struct packed {
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] data;
    logic [c_LANES-1:0]  en;
  } mem_wb_entry_t;

  // Returns {merged_data, merged_en}: lanes enabled in new_en take new_data,
  // all other lanes keep old_data; the enables accumulate.
  function automatic logic [c_DATA_W+c_LANES-1:0] lane_merge(
    input logic [c_DATA_W-1:0] old_data,
    input logic [c_LANES-1:0]  old_en,
    input logic [c_DATA_W-1:0] new_data,
    input logic [c_LANES-1:0]  new_en
  );
    logic [c_DATA_W-1:0] d;
    d = old_data;
    for (int i = 0; i < int'(c_LANES); i++) begin
      if (new_en[i]) begin
        d[c_LANE0_MSB - c_LANE_W*i -: c_LANE_W] = new_data[c_LANE0_MSB - c_LANE_W*i -: c_LANE_W];
      end
    end
    return {d, old_en | new_en};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_addr_cam.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_wb_addr_cam                                            |
// | Description : Parallel word-address compare of one lookup address        |
// |               against every buffer entry, qualified by a valid mask.     |
// | Ports       : addrVec_i  - flattened entry word addresses (entry i at    |
// |                            [i*30 +: 30])                                 |
// |               valid_i    - per-entry valid mask                          |
// |               lookup_i   - word address to search for                    |
// |               match_o    - per-entry hit vector                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_wb_addr_cam
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*c_ADDR_W-1:0] addrVec_i,
  input  logic [DEPTH-1:0]          valid_i,
  input  logic [c_ADDR_W-1:0]       lookup_i,
  output logic [DEPTH-1:0]          match_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match_o[i] = valid_i[i] && (addrVec_i[i*c_ADDR_W +: c_ADDR_W] == lookup_i);
  end

endmodule
`default_nettype wire

// File: rtl/mem_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_write_buffer                                           |
// | Description : In-order store buffer between the write-data encoder and   |
// |               the data memory port. Accepts one lane-encoded store per   |
// |               cycle, drains the head over a req/ack handshake and flags  |
// |               loads that hit a pending or incoming store.                |
// | Config      : MEM_WB_MERGE_EN - when defined, a store to the same word   |
// |               as the youngest entry (count >= 2) merges into it instead  |
// |               of allocating.                                             |
// | Ports       : clk, rstN (sync, active-low)                               |
// |               inAddr/inData/inMW   - store input, inMW == 0 means idle   |
// |               full/empty/count     - occupancy from registered count     |
// |               memReq/memAddr/memData/memEn, memAck - drain handshake     |
// |               rdValid/rdAddr, rdHit - combinational load hazard check    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_write_buffer
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [31:0]      inAddr,
  input  logic [31:0]      inData,
  input  logic [3:0]       inMW,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             memReq,
  output logic [31:0]      memAddr,
  output logic [31:0]      memData,
  output logic [3:0]       memEn,
  input  logic             memAck,
  input  logic             rdValid,
  input  logic [31:0]      rdAddr,
  output logic             rdHit
);

  localparam int PTR_W = CNT_W - 1;

  mem_wb_entry_t          entries_q [DEPTH];
  mem_wb_entry_t          entries_d [DEPTH];
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_merge;
  logic                   w_alloc;
  logic [PTR_W-1:0]       w_tail_prev;
  logic [DEPTH*c_ADDR_W-1:0] w_addr_vec;
  logic [DEPTH-1:0]       w_rd_match;
  logic [c_DATA_W+c_LANES-1:0] w_merged;
  logic                   w_unused_lowbits;

  // Byte offsets are irrelevant: everything is word granular.
  assign w_unused_lowbits = ^{inAddr[1:0], rdAddr[1:0]};

  assign w_full      = (count_q == CNT_W'(DEPTH));
  assign w_empty     = (count_q == '0);
  // A full buffer rejects the store even if the head pops this same cycle.
  assign w_push      = (inMW != 4'b0000) && !w_full;
  assign w_pop       = !w_empty && memAck;
  assign w_tail_prev = tail_q - PTR_W'(1);

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign w_addr_vec[i*c_ADDR_W +: c_ADDR_W] = entries_q[i].addr;
  end

  mem_wb_addr_cam #(
    .DEPTH(DEPTH)
  ) u_rd_cam (
    .addrVec_i (w_addr_vec),
    .valid_i   (valid_q),
    .lookup_i  (rdAddr[31:2]),
    .match_o   (w_rd_match)
  );

`ifdef MEM_WB_MERGE_EN
  logic [DEPTH-1:0] w_merge_match;

  mem_wb_addr_cam #(
    .DEPTH(DEPTH)
  ) u_merge_cam (
    .addrVec_i (w_addr_vec),
    .valid_i   (valid_q),
    .lookup_i  (inAddr[31:2]),
    .match_o   (w_merge_match)
  );

  // With two or more entries the youngest is never the head, so merging
  // cannot disturb an entry that is mid-handshake.
  assign w_merge = w_push && (count_q >= CNT_W'(2)) && w_merge_match[w_tail_prev];
`else
  assign w_merge = 1'b0;
`endif

  assign w_alloc  = w_push && !w_merge;
  assign w_merged = lane_merge(entries_q[w_tail_prev].data, entries_q[w_tail_prev].en,
                               inData, inMW);

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (w_alloc) begin
      entries_d[tail_q] = '{addr: inAddr[31:2], data: inData, en: inMW};
      valid_d[tail_q]   = 1'b1;
      tail_d            = tail_q + PTR_W'(1);
    end

    if (w_merge) begin
      entries_d[w_tail_prev].data = w_merged[c_DATA_W+c_LANES-1:c_LANES];
      entries_d[w_tail_prev].en   = w_merged[c_LANES-1:0];
    end

    if (w_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    case ({w_alloc, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset: it is only observed through valid_q or
  // while the buffer is non-empty.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = count_q;
  assign memReq  = !w_empty;
  assign memAddr = w_empty ? 32'h0 : {entries_q[head_q].addr, 2'b00};
  assign memData = w_empty ? 32'h0 : entries_q[head_q].data;
  assign memEn   = w_empty ? 4'h0  : entries_q[head_q].en;

  assign rdHit = rdValid && rstN &&
                 ((|w_rd_match) || (w_push && (inAddr[31:2] == rdAddr[31:2])));

endmodule
`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_write_buffer                                        |
// | Description : Directed bench for mem_write_buffer. Accepted stores are   |
// |               queued as expected drains; a monitor compares the head on  |
// |               every acked cycle. Occupancy and rdHit are checked inline. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_write_buffer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] inAddr, inData, memAddr, memData, rdAddr;
  logic [3:0]  inMW, memEn;
  logic        full, empty, memReq, memAck, rdValid, rdHit;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  en;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mem_write_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rstN(rstN),
    .inAddr(inAddr), .inData(inData), .inMW(inMW),
    .full(full), .empty(empty), .count(count),
    .memReq(memReq), .memAddr(memAddr), .memData(memData), .memEn(memEn),
    .memAck(memAck),
    .rdValid(rdValid), .rdAddr(rdAddr), .rdHit(rdHit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a store; when it is known to be accepted, queue its expected drain.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit accepted);
    exp_t e;
    inAddr = a;
    inData = d;
    inMW   = m;
    if (accepted) begin
      e = '{addr: {a[31:2], 2'b00}, data: d, en: m};
      sb.push_back(e);
    end
  endtask

  // Monitor: every acked head must match the oldest expected store.
  always @(negedge clk) begin
    exp_t e;
    if (rstN === 1'b1 && memReq === 1'b1 && memAck === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got addr %h expected no request", memAddr);
      end else begin
        e = sb.pop_front();
        chk("drain_addr", memAddr, e.addr);
        chk("drain_data", memData, e.data);
        chk("drain_en", {28'h0, memEn}, {28'h0, e.en});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a matching store and load on the inputs: rdHit stays 0.
    rstN = 1'b0; memAck = 1'b0;
    inAddr = 32'h100; inData = 32'h0; inMW = 4'b1111;
    rdValid = 1'b1; rdAddr = 32'h100;
    tick();
    @(negedge clk);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_memReq", {31'h0, memReq}, 32'h0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memData", memData, 32'h0);
    chk("rst_memEn", {28'h0, memEn}, 32'h0);
    chk("rst_rdHit", {31'h0, rdHit}, 32'h0);
    tick();
    inMW = 4'b0000; rdValid = 1'b0; rstN = 1'b1;
    tick();

    // Single store into empty buffer, presented the next cycle.
    store(32'h100, 32'hAB000000, 4'b0001, 1);
    tick();
    inMW = 4'b0000; memAck = 1'b1;
    @(negedge clk);
    chk("single_memReq", {31'h0, memReq}, 32'h1);
    chk("single_memAddr", memAddr, 32'h100);
    chk("single_memEn", {28'h0, memEn}, 32'h1);
    chk("single_count", {29'h0, count}, 32'h1);
    tick();
    memAck = 1'b0;
    @(negedge clk);
    chk("single_empty", {31'h0, empty}, 32'h1);
    tick();

    // Fill to DEPTH with no acks; the fifth store is rejected.
    for (int i = 0; i < 4; i++) begin
      store(32'h400 + 32'(4*i), 32'hC0DE0000 | 32'(i), 4'b1111, 1);
      tick();
    end
    inMW = 4'b0000;
    @(negedge clk);
    chk("fill_full", {31'h0, full}, 32'h1);
    chk("fill_count", {29'h0, count}, 32'h4);
    store(32'h480, 32'hDEADBEEF, 4'b1111, 0);
    tick();
    inMW = 4'b0000;
    @(negedge clk);
    chk("reject_count", {29'h0, count}, 32'h4);
    // Ack while full: the concurrent push is refused, retry lands next cycle.
    store(32'h500, 32'h55AA55AA, 4'b0110, 0);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    store(32'h500, 32'h55AA55AA, 4'b0110, 1);
    @(negedge clk);
    chk("ack_count", {29'h0, count}, 32'h3);
    chk("ack_full", {31'h0, full}, 32'h0);
    tick();
    inMW = 4'b0000;
    @(negedge clk);
    chk("retry_count", {29'h0, count}, 32'h4);
    memAck = 1'b1;
    repeat (4) tick();
    memAck = 1'b0;
    @(negedge clk);
    chk("fill_drained", {31'h0, empty}, 32'h1);

    // Ten stores with steady push+pop at count 2, crossing pointer wrap.
    for (int i = 0; i < 10; i++) begin
      store(32'h600 + 32'(4*i) + 32'(i % 4), 32'hA0000000 + 32'(i) * 32'h01010101,
            4'((i % 15) + 1), 1);
      if (i >= 2) begin
        memAck = 1'b1;
        @(negedge clk);
        chk("pushpop_count", {29'h0, count}, 32'h2);
      end
      tick();
    end
    inMW = 4'b0000; memAck = 1'b1;
    repeat (2) tick();
    memAck = 1'b0;
    @(negedge clk);
    chk("pushpop_empty", {31'h0, empty}, 32'h1);

    // Load hazard against pending and same-cycle stores.
    store(32'h200, 32'h12345678, 4'b1111, 1);
    tick();
    inMW = 4'b0000; rdValid = 1'b1; rdAddr = 32'h203;
    @(negedge clk);
    chk("hit_pending", {31'h0, rdHit}, 32'h1);
    tick();
    rdAddr = 32'h204;
    @(negedge clk);
    chk("miss_next_word", {31'h0, rdHit}, 32'h0);
    tick();
    store(32'h204, 32'h9ABCDEF0, 4'b0011, 1);
    @(negedge clk);
    chk("hit_incoming", {31'h0, rdHit}, 32'h1);
    tick();
    inMW = 4'b0000; rdValid = 1'b0;

    // Reset while a request is outstanding abandons it.
    @(negedge clk);
    chk("pre_rst_memReq", {31'h0, memReq}, 32'h1);
    tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_memReq", {31'h0, memReq}, 32'h0);
    chk("midrst_count", {29'h0, count}, 32'h0);
    chk("midrst_empty", {31'h0, empty}, 32'h1);
    tick();

`ifdef MEM_WB_MERGE_EN
    // Youngest entry at 0x300 absorbs a second store to the same word.
    begin
      exp_t e;
      store(32'h2F0, 32'h11223344, 4'b1111, 1);
      tick();
      store(32'h300, 32'hAB000000, 4'b0001, 0);
      tick();
      store(32'h300, 32'h000000CD, 4'b1000, 0);
      e = '{addr: 32'h300, data: 32'hAB0000CD, en: 4'b1001};
      sb.push_back(e);
      tick();
      inMW = 4'b0000;
      @(negedge clk);
      chk("merge_count", {29'h0, count}, 32'h2);
      memAck = 1'b1;
      repeat (2) tick();
      memAck = 1'b0;
      @(negedge clk);
      chk("merge_empty", {31'h0, empty}, 32'h1);
      tick();
    end
`endif

    // Buffer still functional after the mid-request reset.
    store(32'h700, 32'h0F0F0F0F, 4'b0101, 1);
    tick();
    inMW = 4'b0000; memAck = 1'b1;
    tick();
    memAck = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", {31'h0, empty}, 32'h1);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
